step_fsm: RTL and testbench
===========================

Name: step_fsm

Overview:
- Debug-unit controller for single-step execution of the pipelined datapath.
- Sequence per step command byte from the UART receiver:
  - enable the datapath for exactly one clock;
  - trigger the data-dump sender;
  - wait for the dump to complete;
  - wait for the next command.
- Ends on an exit command, or when HLT has drained through the pipeline.
- Sits beside the run-mode controller; debug top muxes o_enable/o_send_start by mode.

Parameters:
- UART_BITS, `UART_BITS (8): received byte width
- PROC_BITS, `PROC_BITS (32): instruction width
- CLK_COUNTER_BITS, `CLK_COUNTER_BITS: cycle/step counter width
- STEP_CMD, 8'h73 ('s'): step command byte
- EXIT_CMD, 8'h65 ('e'): exit command byte
- HALT_DRAIN, 3: consecutive HLT-stepped cycles required to end; legal range 1..7
- SEND_TIMEOUT, 16'hFFFF: WAIT_SEND watchdog limit (only with STEP_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_start  in  1  enter step mode (pulse)
- i_rx_data  in  UART_BITS  received byte
- i_rx_done  in  1  i_rx_data valid (1-cycle pulse)
- i_send_done  in  1  data-dump sender finished (pulse)
- i_instruction  in  PROC_BITS  instruction currently fetched
- o_enable  out  1  datapath clock enable
- o_send_start  out  1  start data-dump sender
- o_clk_count  out  CLK_COUNTER_BITS  datapath cycles executed
- o_step_count  out  CLK_COUNTER_BITS  step commands serviced
- o_done  out  1  step session finished (1-cycle pulse)
- o_timeout  out  1  send watchdog fired (only with STEP_TIMEOUT_EN)

Behaviour:
- Interface: reset rst, synchronous, active-low; clock clk.
- Reset: state=IDLE; o_clk_count=0, o_step_count=0, halt_counter=0. All control outputs 0.
- State register is clocked. next_state is combinational; it forces IDLE while rst=0.
- Control outputs are Moore, decoded from state only.

States:
- IDLE: outputs 0. Clears both counters and halt_counter every cycle. i_start=1 -> WAIT_CMD.
- WAIT_CMD: outputs 0. Acts only on cycles with i_rx_done=1:
  - i_rx_data==STEP_CMD -> STEP;
  - i_rx_data==EXIT_CMD -> FINISH;
  - any other byte is ignored (stay).
- STEP: o_enable=1 for exactly this one cycle, always -> SEND_DATA. Same edge:
  - o_clk_count+1 and o_step_count+1, both wrapping modulo 2^CLK_COUNTER_BITS;
  - i_instruction==32'hFFFFFFFF: halt_counter+1, saturating at HALT_DRAIN;
  - otherwise halt_counter=0.
- SEND_DATA: o_send_start=1 for one cycle -> WAIT_SEND.
- WAIT_SEND: outputs 0. On i_send_done:
  - halt_counter==HALT_DRAIN -> FINISH;
  - otherwise -> WAIT_CMD.
- FINISH: o_done=1 for one cycle -> IDLE. Counters hold their values through FINISH; they clear in IDLE.

Latency and timing:
- Step byte accepted at edge N -> o_enable high during cycle N+1 -> o_send_start high during cycle N+2.
- Unknown state encodings -> IDLE.

Boundary conditions:
- i_rx_done outside WAIT_CMD: byte dropped, no buffering.
- i_start outside IDLE: ignored.
- i_send_done outside WAIT_SEND: ignored.
- i_send_done in the same cycle as the SEND_DATA state: ignored; only WAIT_SEND samples it.
- HLT must be stepped on HALT_DRAIN consecutive step commands. Any non-HLT step resets the count.
- EXIT_CMD in WAIT_CMD ends the session without a final dump.
- rst=0 in any state: IDLE on the next edge, counters zeroed, no o_done pulse.

Optional Feature:
- Macro: STEP_TIMEOUT_EN.
- Defined:
  - a 16-bit watchdog counts cycles in WAIT_SEND; it clears on entry to WAIT_SEND;
  - reaching SEND_TIMEOUT without i_send_done -> FINISH, with o_timeout=1 for that FINISH cycle;
  - o_timeout is 0 otherwise and on reset.
- Not defined: no o_timeout port and no watchdog. WAIT_SEND waits indefinitely.

Test Plan:
1. Reset, i_start, rx 8'h73, i_send_done 5 cycles after o_send_start -> exactly one o_enable cycle, one o_send_start pulse, o_clk_count=1, o_step_count=1, back in WAIT_CMD; rx 8'h65 -> o_done pulse, then IDLE with counters 0.
2. In WAIT_CMD, rx 8'h41, then 8'h00 -> no o_enable, counters unchanged; rx 8'h73 -> normal step.
3. i_instruction=32'hFFFFFFFF for 3 steps (HALT_DRAIN=3) -> after third i_send_done, o_done pulses; o_step_count=3 during FINISH.
4. HLT, HLT, non-HLT, HLT, HLT, HLT over six steps -> o_done only after the sixth step's i_send_done.
5. rst=0 asserted in WAIT_SEND after 2 steps -> next cycle IDLE, o_clk_count=0, no o_done; late i_send_done ignored.
6. STEP_TIMEOUT_EN with SEND_TIMEOUT=16'd10, step with i_send_done withheld -> FINISH 10 cycles after entering WAIT_SEND, with o_timeout=1 and o_done=1 in the same cycle.

Source files
------------

// File: rtl/step_if.sv
// rtl/step_if.sv - step_fsm command/handshake bundle; o_timeout present only with STEP_TIMEOUT_EN
`ifndef UART_BITS
`define UART_BITS 8
`endif
`ifndef PROC_BITS
`define PROC_BITS 32
`endif
`ifndef CLK_COUNTER_BITS
`define CLK_COUNTER_BITS 16
`endif

interface step_if #(
    parameter int UART_BITS        = `UART_BITS,
    parameter int PROC_BITS        = `PROC_BITS,
    parameter int CLK_COUNTER_BITS = `CLK_COUNTER_BITS
);
    logic                        i_start;
    logic [UART_BITS-1:0]        i_rx_data;
    logic                        i_rx_done;
    logic                        i_send_done;
    logic [PROC_BITS-1:0]        i_instruction;
    logic                        o_enable;
    logic                        o_send_start;
    logic [CLK_COUNTER_BITS-1:0] o_clk_count;
    logic [CLK_COUNTER_BITS-1:0] o_step_count;
    logic                        o_done;
`ifdef STEP_TIMEOUT_EN
    logic                        o_timeout;
`endif

    modport master (
        output i_start, i_rx_data, i_rx_done, i_send_done, i_instruction,
`ifdef STEP_TIMEOUT_EN
        input  o_timeout,
`endif
        input  o_enable, o_send_start, o_clk_count, o_step_count, o_done
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_done, i_send_done, i_instruction,
`ifdef STEP_TIMEOUT_EN
        output o_timeout,
`endif
        output o_enable, o_send_start, o_clk_count, o_step_count, o_done
    );
endinterface

// File: rtl/step_fsm.sv
// rtl/step_fsm.sv - single-step debug controller; STEP_TIMEOUT_EN adds a WAIT_SEND watchdog
`ifndef UART_BITS
`define UART_BITS 8
`endif
`ifndef PROC_BITS
`define PROC_BITS 32
`endif
`ifndef CLK_COUNTER_BITS
`define CLK_COUNTER_BITS 16
`endif

module step_fsm #(
    parameter int                   UART_BITS        = `UART_BITS,
    parameter int                   PROC_BITS        = `PROC_BITS,
    parameter int                   CLK_COUNTER_BITS = `CLK_COUNTER_BITS,
    parameter logic [UART_BITS-1:0] STEP_CMD         = 8'h73,
    parameter logic [UART_BITS-1:0] EXIT_CMD         = 8'h65,
    parameter int                   HALT_DRAIN       = 3,
    parameter logic [15:0]          SEND_TIMEOUT     = 16'hFFFF
) (
    input logic clk,
    input logic rst,
    step_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WAIT_CMD, STEP, SEND_DATA, WAIT_SEND, FINISH
    } state_t;

    localparam logic [2:0] HALT_MAX = 3'(HALT_DRAIN);

    state_t                      state, next_state;
    logic [2:0]                  halt_cnt;
    logic [CLK_COUNTER_BITS-1:0] clk_cnt, step_cnt;
    logic                        enable_r, send_start_r, done_r;
    logic                        wd_expired;

`ifdef STEP_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        timeout_r;
    assign wd_expired    = (wd_cnt + 16'd1) == SEND_TIMEOUT;
    assign bus.o_timeout = timeout_r;
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (bus.i_start) next_state = WAIT_CMD;
            WAIT_CMD: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == STEP_CMD)      next_state = STEP;
                    else if (bus.i_rx_data == EXIT_CMD) next_state = FINISH;
                end
            end
            STEP:      next_state = SEND_DATA;
            SEND_DATA: next_state = WAIT_SEND;
            WAIT_SEND: begin
                if (bus.i_send_done) next_state = (halt_cnt == HALT_MAX) ? FINISH : WAIT_CMD;
                else if (wd_expired) next_state = FINISH;
            end
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (!rst) next_state = IDLE;
    end

    // Outputs are registered from next_state so each one is a clean Moore decode of state.
    always_ff @(posedge clk) begin
        state        <= next_state;
        enable_r     <= (next_state == STEP);
        send_start_r <= (next_state == SEND_DATA);
        done_r       <= (next_state == FINISH);
        if (next_state == IDLE) begin
            clk_cnt  <= '0;
            step_cnt <= '0;
            halt_cnt <= '0;
        end else if (state == STEP) begin
            clk_cnt  <= clk_cnt + 1'b1;
            step_cnt <= step_cnt + 1'b1;
            if (bus.i_instruction == {PROC_BITS{1'b1}}) begin
                if (halt_cnt != HALT_MAX) halt_cnt <= halt_cnt + 3'd1;
            end else begin
                halt_cnt <= '0;
            end
        end
`ifdef STEP_TIMEOUT_EN
        if (!rst || state != WAIT_SEND) wd_cnt <= '0;
        else                            wd_cnt <= wd_cnt + 16'd1;
        timeout_r <= (state == WAIT_SEND) && (next_state == FINISH) && !bus.i_send_done;
`endif
    end

    assign bus.o_enable     = enable_r;
    assign bus.o_send_start = send_start_r;
    assign bus.o_done       = done_r;
    assign bus.o_clk_count  = clk_cnt;
    assign bus.o_step_count = step_cnt;
endmodule

// File: tb/tb_step_fsm.sv
// tb/tb_step_fsm.sv - directed cycle-vector bench for step_fsm
module tb_step_fsm;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    step_if #(.UART_BITS(8), .PROC_BITS(32), .CLK_COUNTER_BITS(16)) bus ();

    step_fsm #(
        .UART_BITS(8), .PROC_BITS(32), .CLK_COUNTER_BITS(16),
        .STEP_CMD(8'h73), .EXIT_CMD(8'h65), .HALT_DRAIN(3), .SEND_TIMEOUT(16'd10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic        rst, start, rx_done;
        logic [7:0]  rx_data;
        logic        send_done;
        logic        en, ss, done;
        logic [15:0] cc, sc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic st, input logic rd, input logic [7:0] rx,
                                input logic sd, input logic en, input logic ss, input logic dn,
                                input logic [15:0] cc, input logic [15:0] sc);
        vec_t v;
        v.rst = r; v.start = st; v.rx_done = rd; v.rx_data = rx; v.send_done = sd;
        v.en = en; v.ss = ss; v.done = dn; v.cc = cc; v.sc = sc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step_once(input logic [31:0] instr, input logic exp_fin, input string nm);
        @(negedge clk);
        bus.i_instruction = instr;
        bus.i_rx_data     = 8'h73;
        bus.i_rx_done     = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_enable"}, 36'(bus.o_enable), 36'd1);
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_send_start"}, 36'(bus.o_send_start), 36'd1);
        @(posedge clk); #1;
        @(negedge clk);
        bus.i_send_done = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_done"}, 36'(bus.o_done), 36'(exp_fin));
        @(negedge clk);
        bus.i_send_done = 1'b0;
    endtask

    task automatic start_session;
        @(negedge clk); bus.i_start = 1'b1;
        @(negedge clk); bus.i_start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.i_start = 1'b0; bus.i_rx_data = 8'h00; bus.i_rx_done = 1'b0;
        bus.i_send_done = 1'b0; bus.i_instruction = 32'h0;

        //   rst st rd rx     sd   en ss dn  cc     sc
        add(0, 0, 0, 8'h00, 0,   0, 0, 0, 16'd0, 16'd0);  // reset
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd0, 16'd0);
        add(1, 1, 0, 8'h00, 0,   0, 0, 0, 16'd0, 16'd0);  // -> WAIT_CMD
        add(1, 0, 1, 8'h73, 0,   1, 0, 0, 16'd0, 16'd0);  // -> STEP
        add(1, 0, 0, 8'h00, 0,   0, 1, 0, 16'd1, 16'd1);  // -> SEND_DATA
        add(1, 0, 0, 8'h00, 1,   0, 0, 0, 16'd1, 16'd1);  // send_done in SEND_DATA ignored
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd1, 16'd1);
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd1, 16'd1);
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd1, 16'd1);
        add(1, 0, 0, 8'h00, 1,   0, 0, 0, 16'd1, 16'd1);  // -> WAIT_CMD
        add(1, 0, 1, 8'h41, 0,   0, 0, 0, 16'd1, 16'd1);  // unknown byte
        add(1, 0, 1, 8'h00, 0,   0, 0, 0, 16'd1, 16'd1);
        add(1, 1, 0, 8'h00, 0,   0, 0, 0, 16'd1, 16'd1);  // start outside IDLE
        add(1, 0, 0, 8'h00, 1,   0, 0, 0, 16'd1, 16'd1);  // send_done outside WAIT_SEND
        add(1, 0, 1, 8'h73, 0,   1, 0, 0, 16'd1, 16'd1);  // -> STEP
        add(1, 0, 1, 8'h65, 0,   0, 1, 0, 16'd2, 16'd2);  // exit during STEP dropped
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd2, 16'd2);
        add(1, 0, 0, 8'h00, 1,   0, 0, 0, 16'd2, 16'd2);  // -> WAIT_CMD
        add(1, 0, 1, 8'h65, 0,   0, 0, 1, 16'd2, 16'd2);  // -> FINISH
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd0, 16'd0);  // -> IDLE, cleared
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd0, 16'd0);
        add(1, 1, 0, 8'h00, 0,   0, 0, 0, 16'd0, 16'd0);  // reset-in-WAIT_SEND session
        add(1, 0, 1, 8'h73, 0,   1, 0, 0, 16'd0, 16'd0);
        add(1, 0, 0, 8'h00, 0,   0, 1, 0, 16'd1, 16'd1);
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd1, 16'd1);
        add(1, 0, 0, 8'h00, 1,   0, 0, 0, 16'd1, 16'd1);
        add(1, 0, 1, 8'h73, 0,   1, 0, 0, 16'd1, 16'd1);
        add(1, 0, 0, 8'h00, 0,   0, 1, 0, 16'd2, 16'd2);
        add(1, 0, 0, 8'h00, 0,   0, 0, 0, 16'd2, 16'd2);  // in WAIT_SEND
        add(0, 0, 0, 8'h00, 0,   0, 0, 0, 16'd0, 16'd0);  // reset: IDLE, no done
        add(1, 0, 0, 8'h00, 1,   0, 0, 0, 16'd0, 16'd0);  // late send_done ignored
        add(1, 0, 1, 8'h73, 0,   0, 0, 0, 16'd0, 16'd0);  // rx in IDLE ignored

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            bus.i_start     = vecs[i].start;
            bus.i_rx_done   = vecs[i].rx_done;
            bus.i_rx_data   = vecs[i].rx_data;
            bus.i_send_done = vecs[i].send_done;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i),
                36'({bus.o_enable, bus.o_send_start, bus.o_done, bus.o_clk_count, bus.o_step_count}),
                36'({vecs[i].en, vecs[i].ss, vecs[i].done, vecs[i].cc, vecs[i].sc}));
        end
        @(negedge clk);
        rst = 1'b1; bus.i_start = 1'b0; bus.i_rx_done = 1'b0; bus.i_send_done = 1'b0;

        // Three consecutive HLT steps drain the pipeline.
        start_session();
        step_once(32'hFFFF_FFFF, 1'b0, "hlt3_s1");
        step_once(32'hFFFF_FFFF, 1'b0, "hlt3_s2");
        step_once(32'hFFFF_FFFF, 1'b1, "hlt3_s3");
        chk("hlt3_step_count", 36'(bus.o_step_count), 36'd3);
        chk("hlt3_clk_count", 36'(bus.o_clk_count), 36'd3);
        @(posedge clk); #1;
        chk("hlt3_after", 36'({bus.o_done, bus.o_step_count}), 36'd0);

        // A non-HLT step restarts the drain count.
        start_session();
        step_once(32'hFFFF_FFFF, 1'b0, "mix_s1");
        step_once(32'hFFFF_FFFF, 1'b0, "mix_s2");
        step_once(32'h0000_0013, 1'b0, "mix_s3");
        step_once(32'hFFFF_FFFF, 1'b0, "mix_s4");
        step_once(32'hFFFF_FFFF, 1'b0, "mix_s5");
        step_once(32'hFFFF_FFFF, 1'b1, "mix_s6");
        chk("mix_step_count", 36'(bus.o_step_count), 36'd6);
        @(posedge clk); #1;

`ifdef STEP_TIMEOUT_EN
        begin
            int n;
            chk("timeout_idle", 36'(bus.o_timeout), 36'd0);
            start_session();
            bus.i_instruction = 32'h0;
            @(negedge clk);
            bus.i_rx_data = 8'h73; bus.i_rx_done = 1'b1;
            @(negedge clk);
            bus.i_rx_done = 1'b0;
            @(posedge clk);
            @(posedge clk);
            n = 0;
            while (n <= 30) begin
                @(posedge clk); #1;
                n++;
                if (bus.o_done) break;
            end
            chk("timeout_cycles", 36'(n), 36'd10);
            chk("timeout_flags", 36'({bus.o_done, bus.o_timeout}), 36'b11);
            @(posedge clk); #1;
            chk("timeout_clear", 36'({bus.o_done, bus.o_timeout}), 36'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
